// File: rtl/l1_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// l1_mem_arbiter_pkg
// Shared constants for the L1 memory arbiter: FSM state encodings and the
// port identifiers used for the grant/last-owner bookkeeping.
// ---------------------------------------------------------------------------
package l1_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN_I = 2'd1,
        ARB_OWN_D = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    localparam logic ARB_PORT_I = 1'b0;
    localparam logic ARB_PORT_D = 1'b1;

endpackage

// File: rtl/l1_mem_arbiter.sv
// ---------------------------------------------------------------------------
// l1_mem_arbiter
// Shares one main-memory port between the L1 I-cache and D-cache engines.
// One whole-line transaction is granted at a time; the winner's request is
// latched on grant and held on mem_* until mem_ready, then a one-cycle done
// pulse is returned to the owner together with the captured read line.
//
// Ports
//   clock, reset        system clock; synchronous active-low reset
//   i_req/i_addr        I-cache read request (level, held until i_done)
//   i_done/i_rdata      I-cache completion pulse and returned line
//   d_req/d_we/d_addr/  D-cache request: refill (we=0) or writeback (we=1)
//   d_wdata
//   d_done/d_rdata      D-cache completion pulse and returned line
//   mem_req/mem_we/     memory request, held until mem_ready
//   mem_addr/mem_wdata
//   mem_ready/mem_rdata memory completion and read data
//
// Configuration macro
//   ARB_ROUND_ROBIN_EN  defined: round-robin on ties (grant the port that
//                       was not last owner); undefined: D-cache wins ties.
// ---------------------------------------------------------------------------
module l1_mem_arbiter
    import l1_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_done,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    // Doubles as the current owner while in OWN_x/RESP, since it is
    // updated on every grant.
    logic              r_last_owner;
    logic              w_grant;
    logic              w_grant_port;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_i_rdata;
    logic [LINE_W-1:0] r_d_rdata;

    // Next-state, arbitration and decoded outputs.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_port = ARB_PORT_I;
        mem_req      = 1'b0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (i_req || d_req) begin
                    w_grant = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    if (i_req && d_req)
                        w_grant_port = (r_last_owner == ARB_PORT_I) ? ARB_PORT_D : ARB_PORT_I;
                    else
                        w_grant_port = d_req ? ARB_PORT_D : ARB_PORT_I;
`else
                    w_grant_port = d_req ? ARB_PORT_D : ARB_PORT_I;
`endif
                    w_state_next = (w_grant_port == ARB_PORT_D) ? ARB_OWN_D : ARB_OWN_I;
                end
            end
            ARB_OWN_I, ARB_OWN_D: begin
                mem_req = 1'b1;
                if (mem_ready)
                    w_state_next = ARB_RESP;
            end
            ARB_RESP: begin
                i_done       = (r_last_owner == ARB_PORT_I);
                d_done       = (r_last_owner == ARB_PORT_D);
                w_state_next = ARB_IDLE;
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

    // State register plus the latched request and returned-line registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ARB_IDLE;
            r_last_owner <= ARB_PORT_I;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_last_owner <= w_grant_port;
                if (w_grant_port == ARB_PORT_D) begin
                    r_addr  <= d_addr;
                    r_we    <= d_we;
                    r_wdata <= d_wdata;
                end else begin
                    r_addr <= i_addr;
                    r_we   <= 1'b0;
                end
            end
            if (r_state == ARB_OWN_I && mem_ready)
                r_i_rdata <= mem_rdata;
            // Writebacks leave the D-cache's last returned line untouched.
            if (r_state == ARB_OWN_D && mem_ready && !r_we)
                r_d_rdata <= mem_rdata;
        end
    end

    assign mem_we    = r_we & mem_req;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
module tb_l1_mem_arbiter;
    import l1_mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int LW = 128;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_done;
    logic [LW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic          d_done;
    logic [LW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic [LW-1:0] mem_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: last line delivered to each cache and the
    // port that most recently won a grant.
    logic [LW-1:0] m_i_rdata = '0;
    logic [LW-1:0] m_d_rdata = '0;
    logic          m_last    = ARB_PORT_I;

    always #5 clock = ~clock;

    l1_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic tie_winner();
`ifdef ARB_ROUND_ROBIN_EN
        return (m_last == ARB_PORT_I) ? ARB_PORT_D : ARB_PORT_I;
`else
        return ARB_PORT_D;
`endif
    endfunction

    // Serves one granted transaction. Called at the negedge where the
    // requester has just raised (or is holding) its request; the grant must
    // appear as mem_req at the next negedge.
    task automatic serve(input logic port, input logic [AW-1:0] addr, input logic we,
                         input logic [LW-1:0] wdata, input int dly, input logic [LW-1:0] rd);
        int cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!mem_req && cyc < 20);
        check("grant_lat", cyc, 1);
        check("mem_addr", mem_addr, addr);
        check("mem_we", mem_we, we);
        if (we) check("mem_wdata", mem_wdata, wdata);
        m_last = port;
        for (int k = 0; k < dly; k++) begin
            @(negedge clock);
            check("mem_req_hold", mem_req, 1);
            check("early_done", {i_done, d_done}, 0);
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        @(negedge clock);
        mem_ready = 1'b0;
        if (!we) begin
            if (port == ARB_PORT_I) m_i_rdata = rd;
            else                    m_d_rdata = rd;
        end
        check("i_done", i_done, port == ARB_PORT_I);
        check("d_done", d_done, port == ARB_PORT_D);
        check("mem_req_resp", mem_req, 0);
        check("i_rdata", i_rdata, m_i_rdata);
        check("d_rdata", d_rdata, m_d_rdata);
        if (port == ARB_PORT_I) i_req = 1'b0;
        else                    d_req = 1'b0;
        @(negedge clock);
        check("done_one_pulse", {i_done, d_done}, 0);
        check("mem_req_idle", mem_req, 0);
        $display("txn port=%s we=%0d addr=%h dly=%0d rdata=%h", port ? "D" : "I", we, addr, dly, rd);
    endtask

    initial begin
        logic [AW-1:0] a_i, a_d;
        logic [LW-1:0] w_d;
        logic          we_d, win;
        int            mode;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_dones", {i_done, d_done}, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        reset = 1'b1;

        // Reset in the middle of an OWN_D transfer
        @(negedge clock);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
        @(negedge clock);
        check("own_d_mem_req", mem_req, 1);
        reset = 1'b0; d_req = 1'b0;
        @(negedge clock);
        check("midrst_mem_req", mem_req, 0);
        check("midrst_d_done", d_done, 0);
        @(negedge clock);
        check("midrst_d_done2", d_done, 0);
        reset = 1'b1;
        m_last = ARB_PORT_I;
        @(negedge clock);
        check("postrst_d_done", d_done, 0);
        check("postrst_mem_req", mem_req, 0);

        // Directed I-cache refill
        i_req = 1'b1; i_addr = 32'h0000_0040;
        serve(ARB_PORT_I, 32'h0000_0040, 1'b0, '0, 4, {4{32'hA5A5_A5A5}});

        // Directed D-cache writeback
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = {4{32'h1234_5678}};
        serve(ARB_PORT_D, 32'h0000_0100, 1'b1, {4{32'h1234_5678}}, 1, rand_line());

        // Directed simultaneous requests
        i_req = 1'b1; i_addr = 32'h0000_0080;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
        win = tie_winner();
        if (win == ARB_PORT_D) begin
            serve(ARB_PORT_D, 32'h0000_0300, 1'b0, '0, 0, rand_line());
            serve(ARB_PORT_I, 32'h0000_0080, 1'b0, '0, 0, rand_line());
        end else begin
            serve(ARB_PORT_I, 32'h0000_0080, 1'b0, '0, 0, rand_line());
            serve(ARB_PORT_D, 32'h0000_0300, 1'b0, '0, 0, rand_line());
        end

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 3);
            a_i  = $urandom;
            a_d  = $urandom;
            we_d = 1'($urandom_range(0, 1));
            w_d  = rand_line();
            case (mode)
                0: begin
                    i_req = 1'b1; i_addr = a_i;
                    serve(ARB_PORT_I, a_i, 1'b0, '0, $urandom_range(0, 3), rand_line());
                end
                1: begin
                    d_req = 1'b1; d_we = we_d; d_addr = a_d; d_wdata = w_d;
                    serve(ARB_PORT_D, a_d, we_d, w_d, $urandom_range(0, 3), rand_line());
                end
                2: begin
                    i_req = 1'b1; i_addr = a_i;
                    d_req = 1'b1; d_we = we_d; d_addr = a_d; d_wdata = w_d;
                    win = tie_winner();
                    if (win == ARB_PORT_D) begin
                        serve(ARB_PORT_D, a_d, we_d, w_d, $urandom_range(0, 3), rand_line());
                        serve(ARB_PORT_I, a_i, 1'b0, '0, $urandom_range(0, 3), rand_line());
                    end else begin
                        serve(ARB_PORT_I, a_i, 1'b0, '0, $urandom_range(0, 3), rand_line());
                        serve(ARB_PORT_D, a_d, we_d, w_d, $urandom_range(0, 3), rand_line());
                    end
                end
                default: begin
                    // Stray mem_ready while idle must be ignored
                    mem_ready = 1'b1; mem_rdata = rand_line();
                    @(negedge clock);
                    mem_ready = 1'b0;
                    check("stray_done", {i_done, d_done}, 0);
                    check("stray_mem_req", mem_req, 0);
                    @(negedge clock);
                    check("stray_done2", {i_done, d_done}, 0);
                    check("stray_i_rdata", i_rdata, m_i_rdata);
                    check("stray_d_rdata", d_rdata, m_d_rdata);
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
